// File: rtl/pcb_pkg.sv
// Shared definitions for the sequential alphabet pre-computation bank.
package pcb_pkg;

  typedef enum logic [2:0] {StIdle, StC3, StC5, StC7, StHold} pcb_state_e;

  // Guard bits so 7x of a full-scale multiplicand never overflows the bank.
  localparam int unsigned BankGuard = 3;

  // Shift amounts feeding the shared adder for the 3x, 5x and 7x steps.
  localparam int unsigned Shift3 = 1;
  localparam int unsigned Shift5 = 2;
  localparam int unsigned Shift7 = 3;

  function automatic int unsigned bank_width(input int unsigned width);
    return width + BankGuard;
  endfunction

endpackage

// File: rtl/pcb_addsub.sv
// Shared adder/subtractor reused across the three alphabet steps.
module pcb_addsub #(
  parameter int unsigned Width = 19
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] y_o
);

  assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/pre_comp_bank_seq.sv
// Sequential pre-computation bank: 1x/3x/5x/7x of a captured multiplicand using one
// shared adder/subtractor over three cycles, with the weight word carried alongside.
module pre_comp_bank_seq
  import pcb_pkg::*;
#(
  parameter int unsigned LOG2_WIDTH = 4,
  parameter int unsigned WIDTH      = 2 ** LOG2_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       X,
  input  logic [WIDTH-1:0]       W_IN,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+2:0]       I1,
  output logic [WIDTH+2:0]       I3,
  output logic [WIDTH+2:0]       I5,
  output logic [WIDTH+2:0]       I7,
  output logic [WIDTH-1:0]       W_OUT
);

  localparam int unsigned BankW = bank_width(WIDTH);

  pcb_state_e         state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [BankW-1:0]   i1_q, i1_d, i3_q, i3_d, i5_q, i5_d, i7_q, i7_d;

  logic [BankW-1:0]   x_ext;
  logic [BankW-1:0]   op_a, op_b, sum;
  logic               op_sub;
  logic               xfer;

  assign x_ext    = {{BankGuard{1'b0}}, x_q};
  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign xfer     = in_valid && in_ready;

  // Operand steering for the single shared arithmetic unit.
  always_comb begin
    op_a   = x_ext;
    op_b   = x_ext << Shift3;
    op_sub = 1'b0;
    unique case (state_q)
      StC5: op_b = x_ext << Shift5;
      StC7: begin
        op_a   = x_ext << Shift7;
        op_b   = x_ext;
        op_sub = 1'b1;
      end
      default: ;
    endcase
  end

  pcb_addsub #(
    .Width (BankW)
  ) u_addsub (
    .a_i   (op_a),
    .b_i   (op_b),
    .sub_i (op_sub),
    .y_o   (sum)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    i1_d    = i1_q;
    i3_d    = i3_q;
    i5_d    = i5_q;
    i7_d    = i7_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (xfer) begin
          x_d     = X;
          w_d     = W_IN;
          i1_d    = {{BankGuard{1'b0}}, X};
          state_d = StC3;
        end else if (state_q == StHold && out_ready) begin
          state_d = StIdle;
        end
      end
      StC3: begin
        i3_d    = sum;
        state_d = StC5;
      end
      StC5: begin
        i5_d    = sum;
        state_d = StC7;
      end
      StC7: begin
        i7_d    = sum;
        state_d = StHold;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      w_q     <= '0;
      i1_q    <= '0;
      i3_q    <= '0;
      i5_q    <= '0;
      i7_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      i1_q    <= i1_d;
      i3_q    <= i3_d;
      i5_q    <= i5_d;
      i7_q    <= i7_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign I1        = i1_q;
  assign I3        = i3_q;
  assign I5        = i5_q;
  assign I7        = i7_q;
  assign W_OUT     = w_q;

endmodule

// File: doc/pre_comp_bank_seq.md
# pre_comp_bank_seq

Sequential pre-computation bank for the alphabet-set multiplier datapath. It sits directly upstream of the alphabet select unit. It accepts one WIDTH-bit unsigned multiplicand per transaction and produces the alphabet multiples 1x, 3x, 5x and 7x on four WIDTH+3-bit buses (I1, I3, I5, I7) for the select unit. One shared adder/subtractor is reused over three cycles instead of three parallel adders. An accompanying weight word is carried alongside so the downstream nibble-select logic stays aligned with its bank.

## Interface
Parameters:
- LOG2_WIDTH, 4, log2 of the multiplicand width
- WIDTH, 2**LOG2_WIDTH, multiplicand and weight width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  X/W_IN offered
- in_ready  output  1  block can accept X/W_IN this cycle
- X  input  WIDTH  unsigned multiplicand
- W_IN  input  WIDTH  weight word, passed through untouched
- out_valid  output  1  I1/I3/I5/I7/W_OUT hold a complete, stable bank
- out_ready  input  1  downstream consumes the bank this cycle
- I1, I3, I5, I7  output  WIDTH+3  1x, 3x, 5x, 7x of the captured X, zero-extended
- W_OUT  output  WIDTH  weight captured with X

## Operation
- States: IDLE, C3, C5, C7, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). A transfer occurs when in_valid & in_ready.
- IDLE: on a transfer, capture x_reg<=X and W_OUT<=W_IN, set I1<={3'b0,X}, then go to C3. Otherwise stay in IDLE.
- C3: I3 <= x + (x<<1). Go to C5.
- C5: I5 <= x + (x<<2). Go to C7.
- C7: I7 <= (x<<3) - x. Go to HOLD.
- The shared unit is computed at WIDTH+3 bits. 7x max = 7*(2^WIDTH-1) < 2^(WIDTH+3), so no overflow. The subtraction never goes negative.
- HOLD: out_valid=1. All outputs are frozen until out_ready.
  - out_ready & in_valid: back-to-back. Capture the new X/W_IN, reload I1, go to C3.
  - out_ready & !in_valid: go to IDLE. Outputs keep their last values.
  - !out_ready: stay in HOLD. The bank stays stable and new input is not accepted.
- out_valid is high only in HOLD. While in C3/C5/C7, I3/I5/I7 may be partially updated and are undefined for consumers.
- out_valid never rises mid-computation and never drops without an out_ready handshake.
- X = 0 is legal and produces an all-zero bank through the full 3-cycle sequence. There is no shortcut.

## Timing
- Reset (rst_n low, asynchronous, any state): state=IDLE, out_valid=0, I1=I3=I5=I7=0, W_OUT=0, x_reg=0.
- Reset mid-operation aborts the transaction with no output. The first edge after rst_n rises may accept input.
- Latency: transfer at edge k gives out_valid=1 after edge k+3.
- Throughput: one bank per 4 cycles with out_ready held high and back-to-back input.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to any output.
- All other outputs are registered.

## Structure
- Shared package pcb_pkg holds:
  - state enum (IDLE, C3, C5, C7, HOLD)
  - localparam for the bank width WIDTH+3
  - shift-amount constants 1, 2, 3 for the three alphabet steps
- Sub-module pcb_addsub: WIDTH+3-bit adder/subtractor with operands a, b and control sub. It is instantiated once and its operand muxing is driven by state.
- FSM, x_reg and output registers live in the top.

## Test plan
- Reset then single transfer X=5, W_IN=16'hA5A5, out_ready=1 -> out_valid after 3 edges; I1=5, I3=15, I5=25, I7=35, W_OUT=16'hA5A5; next edge out_valid=0.
- X=16'hFFFF -> I1=19'h0FFFF, I3=19'h2FFFD, I5=19'h4FFFB, I7=19'h6FFF9 (no overflow).
- Backpressure: X=3, out_ready=0 for 6 cycles -> out_valid held, I7=21 stable, in_ready=0; raise out_ready with in_valid high, X=7 -> accepted same cycle, I7=49 after 3 more edges.
- Back-to-back stream X=1,2,3,4 with in_valid and out_ready held high -> banks spaced exactly 4 cycles, I3 = 3,6,9,12.
- Assert rst_n low during C5 with X=9 -> all outputs 0 immediately, out_valid never rises for X=9; after release X=2 -> I5=10.
- X=0 -> all-zero bank, out_valid after 3 edges, W_OUT passes through.
